// File: rtl/read_address_traversal.sv
// Read-side walker for the circular telemetry buffer: issues single-word SRAM reads
// from read_addr up to write_addr and hands each word to the consumer via valid/ready.
module read_address_traversal #(
  parameter int                    ADDR_WIDTH   = 17,
  parameter int                    DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR     = '1,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rewind,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  empty,
  output logic [15:0]           words_read
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt;
  logic       issue, capture, accept;

  assign empty = (read_addr == write_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // rewind overrides every transition, including a same-cycle handshake
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    if (rewind) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (enable && !empty) begin
          state_nxt = READ;
          issue     = 1'b1;
        end
        READ: state_nxt = WAIT;
        WAIT: if (lat_cnt == LAT_LAST) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
        HOLD: if (out_ready) begin
          state_nxt = IDLE;
          accept    = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_re     <= 1'b0;
      mem_addr   <= START_ADDR;
      lat_cnt    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      read_addr  <= START_ADDR;
      words_read <= '0;
    end else begin
      mem_re    <= issue;
      out_valid <= (state_nxt == HOLD);
      lat_cnt   <= (state == WAIT) ? lat_cnt + 3'd1 : 3'd0;
      if (issue)
        mem_addr <= read_addr;
      if (capture)
        out_data <= mem_rdata;
      if (rewind)
        read_addr <= START_ADDR;
      else if (accept)
        read_addr <= (read_addr == END_ADDR) ? START_ADDR : read_addr + ADDR_WIDTH'(1);
      if (accept)
        words_read <= words_read + 16'd1;
    end
  end

endmodule

// File: tb/tb_read_address_traversal.sv
// Bench for read_address_traversal: a default-size instance at latency 1 and a small
// 8-word region at latency 3, each with an SRAM model holding addr+0x100.
module tb_read_address_traversal;

  logic clk, reset;
  int   nvec, nerr;

  // instance 0: defaults (17-bit address, latency 1)
  logic        en0, rw0, rdy0, mre0, ov0, emp0;
  logic [16:0] wa0, ma0, ra0;
  logic [15:0] rd0, od0, wr0;
  // instance 1: region 0..7, latency 3
  logic        en1, rw1, rdy1, mre1, ov1, emp1;
  logic [3:0]  wa1, ma1, ra1;
  logic [15:0] rd1, od1, wr1, p1a, p1b;

  logic [16:0] ea0[$];
  logic [15:0] ed0[$];
  logic [3:0]  ea1[$];
  logic [15:0] ed1[$];
  int          hs0[$];

  read_address_traversal u0 (
    .clk(clk), .reset(reset), .enable(en0), .rewind(rw0), .write_addr(wa0),
    .mem_re(mre0), .mem_addr(ma0), .mem_rdata(rd0), .out_data(od0),
    .out_valid(ov0), .out_ready(rdy0), .read_addr(ra0), .empty(emp0),
    .words_read(wr0)
  );

  read_address_traversal #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .START_ADDR(4'd0), .END_ADDR(4'd7), .READ_LATENCY(3)
  ) u1 (
    .clk(clk), .reset(reset), .enable(en1), .rewind(rw1), .write_addr(wa1),
    .mem_re(mre1), .mem_addr(ma1), .mem_rdata(rd1), .out_data(od1),
    .out_valid(ov1), .out_ready(rdy1), .read_addr(ra1), .empty(emp1),
    .words_read(wr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models; 0xdead appears whenever no read was issued
  always @(posedge clk) rd0 <= mre0 ? 16'h100 + ma0[15:0] : 16'hdead;
  always @(posedge clk) begin
    p1a <= mre1 ? 16'h100 + {12'h0, ma1} : 16'hdead;
    p1b <= p1a;
    rd1 <= p1b;
  end

  // monitor for instance 0
  int   cyc0, rc0;
  logic rp0, vp0;
  always @(negedge clk) begin
    if (!reset) begin
      rp0 = 1'b0; vp0 = 1'b0;
    end else begin
      cyc0++;
      if (mre0) begin
        nvec++;
        if (rp0) begin nerr++; $display("FAIL re_consecutive0 mem_re high two cycles at cycle %0d", cyc0); end
        nvec++;
        if (ea0.size() == 0) begin nerr++; $display("FAIL re_unexpected0 mem_addr=%0d, no read expected", ma0); end
        else begin
          logic [16:0] a;
          a = ea0.pop_front();
          if (ma0 !== a) begin nerr++; $display("FAIL mem_addr0 got %0d expected %0d", ma0, a); end
        end
        rc0 = cyc0;
      end
      if (ov0 && !vp0) begin
        nvec++;
        if (cyc0 - rc0 != 2) begin nerr++; $display("FAIL valid_latency0 got %0d expected 2", cyc0 - rc0); end
      end
      if (ov0 && rdy0 && !rw0) begin
        hs0.push_back(cyc0);
        nvec++;
        if (ed0.size() == 0) begin nerr++; $display("FAIL word_unexpected0 out_data=%h", od0); end
        else begin
          logic [15:0] d;
          d = ed0.pop_front();
          if (od0 !== d) begin nerr++; $display("FAIL out_data0 got %h expected %h", od0, d); end
        end
      end
      rp0 = mre0; vp0 = ov0;
    end
  end

  // monitor for instance 1
  int   cyc1, rc1;
  logic rp1, vp1;
  always @(negedge clk) begin
    if (!reset) begin
      rp1 = 1'b0; vp1 = 1'b0;
    end else begin
      cyc1++;
      if (mre1) begin
        nvec++;
        if (rp1) begin nerr++; $display("FAIL re_consecutive1 at cycle %0d", cyc1); end
        nvec++;
        if (ea1.size() == 0) begin nerr++; $display("FAIL re_unexpected1 mem_addr=%0d, no read expected", ma1); end
        else begin
          logic [3:0] a;
          a = ea1.pop_front();
          if (ma1 !== a) begin nerr++; $display("FAIL mem_addr1 got %0d expected %0d", ma1, a); end
        end
        rc1 = cyc1;
      end
      if (ov1 && !vp1) begin
        nvec++;
        if (cyc1 - rc1 != 4) begin nerr++; $display("FAIL valid_latency1 got %0d expected 4", cyc1 - rc1); end
      end
      if (ov1 && rdy1 && !rw1) begin
        nvec++;
        if (ed1.size() == 0) begin nerr++; $display("FAIL word_unexpected1 out_data=%h", od1); end
        else begin
          logic [15:0] d;
          d = ed1.pop_front();
          if (od1 !== d) begin nerr++; $display("FAIL out_data1 got %h expected %h", od1, d); end
        end
      end
      rp1 = mre1; vp1 = ov1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push0(input int a);
    ea0.push_back(17'(a));
    ed0.push_back(16'h100 + 16'(a));
  endtask

  task automatic push1(input int a);
    ea1.push_back(4'(a));
    ed1.push_back(16'h100 + 16'(a));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en0 = 0; rw0 = 0; rdy0 = 0; wa0 = '0;
    en1 = 0; rw1 = 0; rdy1 = 0; wa1 = '0;
    repeat (3) tick();
    nvec++; if (ra0 !== 17'd0) begin nerr++; $display("FAIL rst_read_addr got %0d expected 0", ra0); end
    nvec++; if (mre0 !== 1'b0) begin nerr++; $display("FAIL rst_mem_re got %b expected 0", mre0); end
    nvec++; if (ma0 !== 17'd0) begin nerr++; $display("FAIL rst_mem_addr got %0d expected 0", ma0); end
    nvec++; if (od0 !== 16'h0) begin nerr++; $display("FAIL rst_out_data got %h expected 0", od0); end
    nvec++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b expected 0", ov0); end
    nvec++; if (wr0 !== 16'd0) begin nerr++; $display("FAIL rst_words_read got %0d expected 0", wr0); end
    nvec++; if (emp0 !== 1'b1) begin nerr++; $display("FAIL rst_empty got %b expected 1", emp0); end
    nvec++; if (ra1 !== 4'd0) begin nerr++; $display("FAIL rst_read_addr1 got %0d expected 0", ra1); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    hs0.delete();
    for (int i = 0; i < 5; i++) push0(i);
    rdy0 = 1'b1; wa0 = 17'd5; en0 = 1'b1;
    for (int i = 0; i < 100 && wr0 != 16'd5; i++) tick();
    tick();
    nvec++; if (wr0 !== 16'd5) begin nerr++; $display("FAIL stream_words got %0d expected 5", wr0); end
    nvec++; if (ra0 !== 17'd5) begin nerr++; $display("FAIL stream_read_addr got %0d expected 5", ra0); end
    nvec++; if (emp0 !== 1'b1) begin nerr++; $display("FAIL stream_empty got %b expected 1", emp0); end
    nvec++; if (ea0.size() != 0 || ed0.size() != 0) begin nerr++; $display("FAIL stream_drain got %0d/%0d left expected 0/0", ea0.size(), ed0.size()); end
    nvec++;
    if (hs0.size() != 5) begin nerr++; $display("FAIL stream_count got %0d handshakes expected 5", hs0.size()); end
    else for (int i = 1; i < 5; i++) begin
      nvec++;
      if (hs0[i] - hs0[i-1] != 4) begin nerr++; $display("FAIL stream_spacing got %0d expected 4", hs0[i] - hs0[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    rdy0 = 1'b0;
    push0(5);
    wa0 = 17'd6;
    for (int i = 0; i < 20 && !ov0; i++) tick();
    nvec++; if (ov0 !== 1'b1) begin nerr++; $display("FAIL bp_valid got %b expected 1", ov0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++;
      if (ov0 !== 1'b1 || od0 !== 16'h105 || ra0 !== 17'd5 || mre0 !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold got v=%b d=%h ra=%0d re=%b expected v=1 d=0105 ra=5 re=0", ov0, od0, ra0, mre0);
      end
    end
    rdy0 = 1'b1;
    for (int i = 0; i < 20 && wr0 != 16'd6; i++) tick();
    nvec++; if (wr0 !== 16'd6) begin nerr++; $display("FAIL bp_words got %0d expected 6", wr0); end
    nvec++; if (ra0 !== 17'd6) begin nerr++; $display("FAIL bp_read_addr got %0d expected 6", ra0); end
  endtask

  task automatic test_wrap_latency();
    for (int i = 0; i < 6; i++) push1(i);
    rdy1 = 1'b1; wa1 = 4'd6; en1 = 1'b1;
    for (int i = 0; i < 200 && wr1 != 16'd6; i++) tick();
    nvec++; if (ra1 !== 4'd6) begin nerr++; $display("FAIL wrap_pre_addr got %0d expected 6", ra1); end
    push1(6); push1(7); push1(0); push1(1);
    wa1 = 4'd2;
    for (int i = 0; i < 200 && wr1 != 16'd10; i++) tick();
    tick();
    en1 = 1'b0;
    nvec++; if (wr1 !== 16'd10) begin nerr++; $display("FAIL wrap_words got %0d expected 10", wr1); end
    nvec++; if (ra1 !== 4'd2) begin nerr++; $display("FAIL wrap_read_addr got %0d expected 2", ra1); end
    nvec++; if (emp1 !== 1'b1) begin nerr++; $display("FAIL wrap_empty got %b expected 1", emp1); end
    nvec++; if (ea1.size() != 0 || ed1.size() != 0) begin nerr++; $display("FAIL wrap_drain got %0d/%0d left expected 0/0", ea1.size(), ed1.size()); end
  endtask

  task automatic test_rewind();
    // rewind during WAIT
    rdy0 = 1'b0;
    push0(6);
    wa0 = 17'd8;
    for (int i = 0; i < 20 && !mre0; i++) tick();
    tick();
    rw0 = 1'b1;
    tick();
    rw0 = 1'b0; en0 = 1'b0;
    nvec++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL rw_wait_valid got %b expected 0", ov0); end
    nvec++; if (ra0 !== 17'd0) begin nerr++; $display("FAIL rw_wait_addr got %0d expected 0", ra0); end
    nvec++; if (wr0 !== 16'd6) begin nerr++; $display("FAIL rw_wait_words got %0d expected 6", wr0); end
    nvec++; if (mre0 !== 1'b0) begin nerr++; $display("FAIL rw_wait_re got %b expected 0", mre0); end
    if (ed0.size() > 0) void'(ed0.pop_front());
    repeat (3) tick();
    nvec++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL rw_discard got valid %b expected 0", ov0); end
    // rewind coinciding with a handshake in HOLD
    push0(0);
    en0 = 1'b1;
    for (int i = 0; i < 20 && !ov0; i++) tick();
    rdy0 = 1'b1; rw0 = 1'b1;
    tick();
    rdy0 = 1'b0; rw0 = 1'b0; en0 = 1'b0;
    nvec++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL rw_hold_valid got %b expected 0", ov0); end
    nvec++; if (ra0 !== 17'd0) begin nerr++; $display("FAIL rw_hold_addr got %0d expected 0", ra0); end
    nvec++; if (wr0 !== 16'd6) begin nerr++; $display("FAIL rw_hold_words got %0d expected 6", wr0); end
    if (ed0.size() > 0) void'(ed0.pop_front());
    tick();
  endtask

  task automatic test_async_reset();
    push0(0);
    en0 = 1'b1;
    for (int i = 0; i < 20 && !ov0; i++) tick();
    #1 reset = 1'b0;
    #1;
    nvec++;
    if (ov0 !== 1'b0 || mre0 !== 1'b0 || ma0 !== 17'd0 || od0 !== 16'h0 || ra0 !== 17'd0 || wr0 !== 16'd0) begin
      nerr++;
      $display("FAIL arst_outputs got v=%b re=%b ma=%0d d=%h ra=%0d wr=%0d expected all 0", ov0, mre0, ma0, od0, ra0, wr0);
    end
    nvec++; if (ra1 !== 4'd0 || wr1 !== 16'd0) begin nerr++; $display("FAIL arst_outputs1 got ra=%0d wr=%0d expected 0/0", ra1, wr1); end
    ea0.delete(); ed0.delete();
    en0 = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    wa0 = 17'd2;
    push0(0); push0(1);
    rdy0 = 1'b1; en0 = 1'b1;
    for (int i = 0; i < 50 && wr0 != 16'd2; i++) tick();
    tick();
    nvec++; if (wr0 !== 16'd2) begin nerr++; $display("FAIL resume_words got %0d expected 2", wr0); end
    nvec++; if (ra0 !== 17'd2) begin nerr++; $display("FAIL resume_addr got %0d expected 2", ra0); end
    nvec++; if (emp0 !== 1'b1) begin nerr++; $display("FAIL resume_empty got %b expected 1", emp0); end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    cyc0 = 0; rc0 = 0; cyc1 = 0; rc1 = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap_latency();
    test_rewind();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/read_address_traversal.md
# read_address_traversal

Read-side address generator for the circular telemetry buffer in on-board SRAM. It walks the buffer from its own read pointer up to the live write pointer supplied by the write-side traversal. It issues single-word reads to the synchronous SRAM and presents each word to the downstream consumer (downlink/flash formatter) with a valid/ready handshake. The block is the reader counterpart of the write address traversal and shares the same address space and wrap rules.

## Interface

Parameters:
- ADDR_WIDTH, 17, width of the SRAM word address
- DATA_WIDTH, 16, SRAM word width
- START_ADDR, 0, first address of the circular region
- END_ADDR, 2^ADDR_WIDTH-1, last address of the circular region; START_ADDR < END_ADDR
- READ_LATENCY, 1, cycles from mem_re to valid mem_rdata; legal values 1..4

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; permits new reads to be issued
- rewind  in  1  single-cycle pulse; return read pointer to START_ADDR
- write_addr  in  ADDR_WIDTH  next address the writer will fill, driven by the write traversal
- mem_re  out  1  SRAM read strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  SRAM read address, valid while mem_re=1
- mem_rdata  in  DATA_WIDTH  SRAM read data
- out_data  out  DATA_WIDTH  word to consumer
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- read_addr  out  ADDR_WIDTH  current read pointer
- empty  out  1  combinational: read_addr == write_addr
- words_read  out  16  count of accepted words, wraps at 65535 -> 0

## Operation

- Reset values: read_addr=START_ADDR, mem_re=0, mem_addr=START_ADDR, out_data=0, out_valid=0, words_read=0, state IDLE.
- The FSM has four states: IDLE, READ, WAIT, HOLD.
- IDLE: if enable=1, empty=0 and rewind=0, go to READ. Otherwise remain.
- READ (one cycle): mem_re=1 and mem_addr=read_addr, both registered. Go to WAIT.
- WAIT: count READ_LATENCY cycles after the READ cycle, then sample mem_rdata into out_data, set out_valid=1, and go to HOLD.
- HOLD: hold out_data and out_valid until out_ready=1. On the accepting cycle:
  - read_addr advances: it wraps from END_ADDR to START_ADDR, otherwise it increments by 1.
  - words_read increments.
  - The next state is IDLE with out_valid=0.
- out_data is stable while out_valid=1. out_ready is ignored when out_valid=0.
- Dropping enable only blocks new issues. An in-flight word still completes through HOLD.
- A change in write_addr during a transaction does not affect that transaction. empty is re-evaluated in IDLE only.
- rewind has priority in every state. On the next edge: state=IDLE, read_addr=START_ADDR, mem_re=0, out_valid=0. The in-flight word is discarded and words_read is unchanged.
  - If rewind coincides with an out_ready handshake in HOLD, the rewind wins: no increment, and the word counts as not accepted.
- Overrun protection (writer lapping the reader) is outside this block. empty compares pointers only.
- Asynchronous reset mid-operation returns all outputs to reset values immediately.

## Timing

- With IDLE decision in cycle 0:
  - mem_re=1 in cycle 1.
  - mem_rdata sampled at the end of cycle 1+READ_LATENCY.
  - out_valid=1 from cycle 2+READ_LATENCY.
- Handshake in cycle H: out_valid=0 and the new read_addr are visible in cycle H+1 (IDLE). The next mem_re is no earlier than H+2.
- Maximum throughput is one word per READ_LATENCY+3 cycles: 4 cycles at READ_LATENCY=1 with out_ready held high.
- mem_re is never high for two consecutive cycles.

## Test plan

- Reset, then write_addr=5, enable=1, out_ready=1, READ_LATENCY=1, SRAM preloaded data=addr+0x100 -> 5 words 0x100..0x104 at one per 4 cycles; empty=1 afterward; words_read=5; mem_addr 0..4.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> out_data and out_valid held constant; read_addr unchanged; no mem_re until handshake.
- Wrap: START_ADDR=0, END_ADDR=7, read pointer at 6, write_addr=2 -> reads addresses 6, 7, 0, 1; read_addr=2; empty=1.
- rewind asserted in the WAIT cycle and again in a HOLD cycle with out_ready=1 -> next cycle IDLE, read_addr=START_ADDR, out_valid=0, words_read unchanged.
- READ_LATENCY=3 -> out_valid rises exactly 4 cycles after the mem_re cycle; the captured data matches the address.
- Mid-transaction reset asserted low asynchronously -> all outputs at reset values before the next clk edge; normal operation resumes after release.
